s_coef_streamer: RTL and testbench
==================================

Name: s_coef_streamer

Overview:
- Downstream of the secret-key decoder. Latches the three decoded secret polynomials s[0..2], each 256 x 12-bit coefficients.
- Streams them as coefficient pairs (2j, 2j+1) over a valid/ready interface into the base-multiplication / s^T*u datapath of decapsulation.
- Flags any coefficient >= Q as a sticky error.

Parameters:
- K, 3, number of polynomials in s (Kyber768)
- N, 256, coefficients per polynomial
- W, 12, coefficient width in bits
- Q, 3329, modulus used for the range check

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_in[0:K-1]  in  N*W each  decoded s polynomials; coefficient i at bits [i*W +: W]
- start  in  1  one-cycle request to capture s_in and begin streaming
- busy  out  1  high from the capture edge until the last beat is accepted
- out_valid  out  1  coefficient pair available
- out_ready  in  1  consumer accepts the pair
- out_pair  out  2*W  [W-1:0] = coef 2j, [2W-1:W] = coef 2j+1
- out_poly  out  2  polynomial index 0..K-1 of the current beat
- out_idx  out  7  pair index j, 0..N/2-1
- out_last_poly  out  1  high when out_idx == N/2-1
- out_last  out  1  high on the final beat (poly K-1, idx N/2-1)
- done  out  1  one-cycle pulse when the final beat is accepted
- coef_err  out  1  sticky; set if any streamed coefficient >= Q

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - busy=0, out_valid=0, done=0, coef_err=0.
  - out_pair=0, out_poly=0, out_idx=0, out_last_poly=0, out_last=0.
  - Internal buffer contents are don't-care.
- Reset mid-stream aborts immediately. No done pulse. Return to IDLE.
- States:
  - IDLE: start=1 at a clock edge latches all K*N*W bits of s_in into an internal buffer, clears coef_err, sets poly=0 and idx=0, and enters STREAM. busy=1 and out_valid=1 are visible the cycle after the start edge. Latency is 1 cycle.
  - STREAM: out_valid=1 continuously. A beat transfers on a rising edge with out_valid & out_ready.
    - On transfer with idx < N/2-1: idx increments by 1.
    - On transfer with idx = N/2-1 and poly < K-1: idx wraps to 0 and poly increments.
    - On transfer of the final beat: enter IDLE. busy=0, out_valid=0 and done=1 in the following cycle; done lasts exactly 1 cycle.
- Output stability: while out_valid=1 and out_ready=0, out_pair, out_poly, out_idx, out_last_poly and out_last hold their values. The consumer may hold out_ready=0 indefinitely.
- Output data source: out_pair is taken from the latched buffer, never live from s_in. Changing s_in during STREAM has no effect.
- start handling:
  - start during STREAM is ignored; no restart or re-latch.
  - start in the cycle where done=1 (state already IDLE) is accepted and begins a new stream.
- out_valid does not depend combinationally on out_ready.
- Range check:
  - On each transfer, coef_err is set if either coefficient of the pair is >= Q (unsigned 12-bit compare).
  - coef_err stays set until the next accepted start or reset.
  - The stream continues regardless of coef_err.
- Throughput: with out_ready held at 1, one beat per cycle. The full stream is K*N/2 = 384 beats. done appears 384 cycles after out_valid first rises.

Test Plan:
- Ramp data: poly p coefficient i = (p*256+i) mod 3329. Apply start, hold out_ready=1.
  - First beat: out_pair={12'd1,12'd0}, poly 0, idx 0.
  - Beat 128: poly 1, idx 0, pair={12'd257,12'd256}.
  - 384 beats in total, out_last only on beat 383, done 1 cycle later, busy low with it, coef_err=0.
- Backpressure: toggle out_ready pseudo-randomly. Each pair must be transferred exactly once, in order. Outputs must be stable during stall cycles. Completion count is 384 transfers.
- Range error: set s[2] coefficient 77 = 3329 and all others 0. Expect coef_err rising after the transfer of poly 2, idx 38. It stays 1 after done, then clears on the next start.
- start while busy: pulse start at beat 50 with different s_in. The stream must be unchanged, 384 beats total, taken from the originally latched data.
- Back-to-back runs: assert start in the done cycle. New stream begins the next cycle with poly 0, idx 0 from the new s_in.
- Reset mid-stream: drop rst_n at beat 200. All outputs go to 0 asynchronously and no done pulse occurs. After release, a fresh start gives a full 384-beat stream.

Source files
------------

// File: rtl/s_coef_streamer.sv
// s_coef_streamer
//   Captures the K decoded secret polynomials s[0..K-1] (N coefficients of
//   W bits each) on a start request. It then streams them as coefficient
//   pairs (2j, 2j+1) over a valid/ready interface to the s^T*u datapath.
//   Any streamed coefficient >= Q raises a sticky error flag.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   s_in[0:K-1]       decoded polynomials, coefficient i at [i*W +: W]
//   start             request: capture s_in and begin streaming (IDLE only)
//   busy              high from the capture edge until the last beat is taken
//   out_valid/ready   pair handshake (see below)
//   out_pair          {coef 2j+1, coef 2j}
//   out_poly/out_idx  polynomial index and pair index j of the current beat
//   out_last_poly     current beat is the last pair of its polynomial
//   out_last          current beat is the final beat of the whole stream
//   done              one-cycle pulse after the final beat is accepted
//   coef_err          sticky range error, cleared by the next accepted start
//   dbg_state         current FSM state (0 = IDLE, 1 = STREAM)
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready. While
// out_valid=1 and out_ready=0 every out_* payload signal holds its value.
module s_coef_streamer #(
  parameter int K = 3,
  parameter int N = 256,
  parameter int W = 12,
  parameter int Q = 3329
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   s_in [0:K-1],
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_pair,
  output logic [1:0]       out_poly,
  output logic [6:0]       out_idx,
  output logic             out_last_poly,
  output logic             out_last,
  output logic             done,
  output logic             coef_err,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  localparam logic [6:0]   IDX_LAST  = 7'(N/2 - 1);
  localparam logic [1:0]   POLY_LAST = 2'(K - 1);
  localparam logic [W-1:0] Q_W       = W'(Q);

  state_e     state_q, state_d;
  logic [1:0] poly_q, poly_d;
  logic [6:0] idx_q, idx_d;
  logic       coef_err_q, coef_err_d;
  logic       done_q, done_d;
  logic       load;

  // Capture buffer. Its contents are meaningless until the first start, so
  // it carries no reset.
  logic [N*W-1:0] coef_buf_q [0:K-1];

  logic [2*W-1:0] pair_raw;
  logic [W-1:0]   coef_lo, coef_hi;

  assign pair_raw = coef_buf_q[poly_q][int'(idx_q)*2*W +: 2*W];
  assign coef_lo  = pair_raw[W-1:0];
  assign coef_hi  = pair_raw[2*W-1:W];

  always_ff @(posedge clk) begin
    if (load) begin
      coef_buf_q <= s_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      poly_q     <= '0;
      idx_q      <= '0;
      coef_err_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      poly_q     <= poly_d;
      idx_q      <= idx_d;
      coef_err_q <= coef_err_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    poly_d     = poly_q;
    idx_d      = idx_q;
    coef_err_d = coef_err_q;
    done_d     = 1'b0;
    load       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          coef_err_d = 1'b0;
          poly_d     = '0;
          idx_d      = '0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        // start is deliberately ignored here: no restart, no re-latch.
        if (out_ready) begin
          if (coef_lo >= Q_W || coef_hi >= Q_W) begin
            coef_err_d = 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (poly_q == POLY_LAST) begin
              // poly/idx return to 0 so the idle outputs read as zero.
              poly_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              poly_d = poly_q + 2'd1;
            end
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic streaming;
  assign streaming     = (state_q == S_STREAM);
  assign busy          = streaming;
  assign out_valid     = streaming;
  // Gate the buffer read so the idle/reset value is zero regardless of the
  // unreset buffer contents.
  assign out_pair      = streaming ? pair_raw : '0;
  assign out_poly      = poly_q;
  assign out_idx       = idx_q;
  assign out_last_poly = streaming && (idx_q == IDX_LAST);
  assign out_last      = streaming && (idx_q == IDX_LAST) && (poly_q == POLY_LAST);
  assign done          = done_q;
  assign coef_err      = coef_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_s_coef_streamer.sv
// Testbench for s_coef_streamer: ramp, backpressure, range error, start
// while busy, back-to-back runs and reset mid-stream, all checked against
// an expected-beat queue built from a coefficient array.
module tb_s_coef_streamer;

  localparam int K     = 3;
  localparam int N     = 256;
  localparam int W     = 12;
  localparam int Q     = 3329;
  localparam int NP    = N / 2;
  localparam int BEATS = K * NP;
  localparam int EW    = 2*W + 2 + 7 + 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N*W-1:0] s_in [0:K-1];
  logic           start;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_pair;
  logic [1:0]     out_poly;
  logic [6:0]     out_idx;
  logic           out_last_poly;
  logic           out_last;
  logic           done;
  logic           coef_err;
  logic           dbg_state;

  s_coef_streamer #(.K(K), .N(N), .W(W), .Q(Q)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (s_in),
    .start         (start),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pair      (out_pair),
    .out_poly      (out_poly),
    .out_idx       (out_idx),
    .out_last_poly (out_last_poly),
    .out_last      (out_last),
    .done          (done),
    .coef_err      (coef_err),
    .dbg_state     (dbg_state)
  );

  // reference model: coefficient array plus expected beat queue
  logic [W-1:0]  coef [0:K-1][0:N-1];
  logic [EW-1:0] exp_q[$];
  bit            err_model;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // mode 0 ramp, 1 random in range, 2 random full width, 3 all zero
  task automatic fill(input int mode);
    for (int p = 0; p < K; p++)
      for (int i = 0; i < N; i++)
        case (mode)
          0:       coef[p][i] = W'((p*N + i) % Q);
          1:       coef[p][i] = W'($urandom_range(0, Q-1));
          2:       coef[p][i] = W'($urandom_range(0, 4095));
          default: coef[p][i] = '0;
        endcase
  endtask

  task automatic drive_s_in();
    for (int p = 0; p < K; p++)
      for (int i = 0; i < N; i++)
        s_in[p][i*W +: W] = coef[p][i];
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int p = 0; p < K; p++)
      for (int j = 0; j < NP; j++)
        exp_q.push_back({coef[p][2*j+1], coef[p][2*j], 2'(p), 7'(j),
                         1'(j == NP-1), 1'(p == K-1 && j == NP-1)});
  endtask

  // driver: called at a negedge while the DUT is idle (or in its done cycle)
  task automatic start_run();
    drive_s_in();
    build_exp();
    err_model = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",  busy, 1);
    check("start_valid", out_valid, 1);
    check("start_done",  done, 0);
    check("start_err",   coef_err, 0);
  endtask

  // Consumes beats until `target` transfers happened. poke_at >= 0 pulses
  // start with fresh random s_in once that many beats have been taken.
  task automatic stream(input int rdy_pct, input int poke_at, input int target,
                        output int beats, output int cycles);
    logic [EW-1:0] e, cur, held;
    bit stalled;
    stalled = 0;
    beats = 0;
    cycles = 0;
    while (beats < target && cycles < 20000) begin
      cur = {out_pair, out_poly, out_idx, out_last_poly, out_last};
      check("valid", out_valid, 1);
      check("busy", busy, 1);
      check("done_low", done, 0);
      check("err_run", coef_err, err_model);
      if (stalled) check("stall_hold", cur, held);
      start = (beats == poke_at);
      if (beats == poke_at) begin
        fill(2);
        drive_s_in();
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (out_ready) begin
        e = exp_q.pop_front();
        check("beat", cur, e);
        if (e[EW-1 -: W] >= W'(Q) || e[EW-W-1 -: W] >= W'(Q)) err_model = 1'b1;
        beats++;
        stalled = 0;
      end else begin
        stalled = 1;
        held = cur;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (beats < target) check("timeout", 1, 0);
  endtask

  // checks in the cycle after the final beat was accepted
  task automatic end_checks();
    check("end_done",  done, 1);
    check("end_busy",  busy, 0);
    check("end_valid", out_valid, 0);
    check("end_last",  out_last, 0);
    check("end_err",   coef_err, err_model);
    check("end_queue", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_err"},   coef_err, 0);
    check({tag, "_outs"},  {out_pair, out_poly, out_idx, out_last_poly, out_last}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int b, c;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    fill(3);
    drive_s_in();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ramp, full throughput
    fill(0);
    start_run();
    check("first_pair", out_pair, 24'h001000);
    stream(100, -1, BEATS, b, c);
    check("throughput_cycles", c, BEATS);
    end_checks();
    @(negedge clk);
    check("done_width", done, 0);

    // random data, random backpressure
    fill(1);
    start_run();
    stream(55, -1, BEATS, b, c);
    end_checks();
    @(negedge clk);

    // range error in s[2] coefficient 77 (pair idx 38)
    fill(3);
    coef[2][77] = W'(Q);
    start_run();
    stream(70, -1, BEATS, b, c);
    end_checks();
    check("err_after_done", coef_err, 1);
    @(negedge clk);
    check("err_sticky", coef_err, 1);

    // start while busy at beat 50 (start_run also checks error is cleared)
    fill(0);
    start_run();
    stream(80, 50, BEATS, b, c);
    end_checks();

    // back-to-back: start in the done cycle, full-range random data
    fill(2);
    start_run();
    check("b2b_poly", out_poly, 0);
    check("b2b_idx",  out_idx, 0);
    stream(100, -1, BEATS, b, c);
    end_checks();
    @(negedge clk);

    // reset mid-stream at beat 200
    fill(1);
    start_run();
    stream(100, -1, 200, b, c);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");
    fill(1);
    start_run();
    stream(60, -1, BEATS, b, c);
    end_checks();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
